// File: rtl/jstk_input_conditioner_pkg.sv
// Shared constants, packet layout and repeat-FSM state type for the joystick conditioner.
package jstk_input_conditioner_pkg;

    localparam int unsigned GRID_N   = 9;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned AXIS_W   = 10;
    localparam int unsigned PKT_W    = 40;
    localparam int unsigned LO_TH    = 350;
    localparam int unsigned HI_TH    = 650;
    localparam int unsigned HYST     = 25;
    localparam int unsigned AXIS_MID = 512;

    // Raw PmodJSTK packet, MSB first (bits 39..0).
    typedef struct packed {
        logic [7:0] y_lo;       // 39:32
        logic [5:0] rsvd_y;     // 31:26
        logic [1:0] y_hi;       // 25:24
        logic [7:0] x_lo;       // 23:16
        logic [5:0] rsvd_x;     // 15:10
        logic [1:0] x_hi;       // 9:8
        logic [4:0] rsvd_b;     // 7:3
        logic       btn_z;      // 2
        logic       rsvd_b1;    // 1
        logic       btn_c;      // 0
    } jstk_pkt_t;

    // Fields kept between strobes.
    typedef struct packed {
        logic [AXIS_W-1:0] x;
        logic [AXIS_W-1:0] y;
        logic              btn_c;
        logic              btn_z;
    } jstk_fields_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Move one cursor coordinate by at most one cell, clamped to the grid.
    function automatic logic [COORD_W-1:0] step_coord(
        input logic [COORD_W-1:0] cur,
        input logic               dec,
        input logic               inc
    );
        logic [COORD_W-1:0] res;
        res = cur;
        if (dec && (cur != COORD_W'(0))) begin
            res = cur - COORD_W'(1);
        end else if (inc && (cur != COORD_W'(GRID_N - 1))) begin
            res = cur + COORD_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/jstk_input_conditioner_if.sv
// Joystick packet input and game-control outputs of the conditioner.
interface jstk_input_conditioner_if;
    import jstk_input_conditioner_pkg::*;

    logic [PKT_W-1:0]   jstk_data;
    logic               jstk_valid;
    logic [COORD_W-1:0] sel_row;
    logic [COORD_W-1:0] sel_col;
    logic               move_pulse;
    logic               place_pulse;
    logic               fire_pulse;

    modport master (
        output jstk_data,
        output jstk_valid,
        input  sel_row,
        input  sel_col,
        input  move_pulse,
        input  place_pulse,
        input  fire_pulse
    );

    modport slave (
        input  jstk_data,
        input  jstk_valid,
        output sel_row,
        output sel_col,
        output move_pulse,
        output place_pulse,
        output fire_pulse
    );

endinterface

// File: rtl/jstk_input_conditioner_axis.sv
// One joystick axis: hysteresis direction decode plus hold-to-repeat step generator.
module jstk_input_conditioner_axis
    import jstk_input_conditioner_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY_CYC = 40_000_000,
    parameter int unsigned REPEAT_CYC       = 15_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AXIS_W-1:0] axis_val,
    output logic              step_neg_c,
    output logic              step_pos_c
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY_CYC > REPEAT_CYC) ? REPEAT_DELAY_CYC : REPEAT_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic             neg_q, neg_d;
    logic             pos_q, pos_d;
    rpt_state_e       state_q, state_d;
    logic             dir_pos_q, dir_pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_any_c;

    // Direction flags: engage outside the thresholds, release only past the hysteresis band.
    always_comb begin
        neg_d = neg_q;
        pos_d = pos_q;
        if (axis_val < AXIS_W'(LO_TH)) begin
            neg_d = 1'b1;
        end else if (axis_val >= AXIS_W'(LO_TH + HYST)) begin
            neg_d = 1'b0;
        end
        if (axis_val > AXIS_W'(HI_TH)) begin
            pos_d = 1'b1;
        end else if (axis_val <= AXIS_W'(HI_TH - HYST)) begin
            pos_d = 1'b0;
        end
    end

    // Repeat FSM: immediate step on engage or reversal, then delayed auto-repeat.
    always_comb begin
        state_d    = state_q;
        dir_pos_d  = dir_pos_q;
        cnt_d      = cnt_q;
        step_any_c = 1'b0;
        case (state_q)
            RPT_IDLE: begin
                if (neg_q || pos_q) begin
                    state_d    = RPT_HOLD;
                    dir_pos_d  = pos_q;
                    cnt_d      = '0;
                    step_any_c = 1'b1;
                end
            end
            RPT_HOLD, RPT_REPEAT: begin
                if (!(neg_q || pos_q)) begin
                    state_d = RPT_IDLE;
                    cnt_d   = '0;
                end else if (pos_q != dir_pos_q) begin
                    state_d    = RPT_HOLD;
                    dir_pos_d  = pos_q;
                    cnt_d      = '0;
                    step_any_c = 1'b1;
                end else if ((state_q == RPT_HOLD) && (cnt_q == CNT_W'(REPEAT_DELAY_CYC - 1))) begin
                    state_d    = RPT_REPEAT;
                    cnt_d      = '0;
                    step_any_c = 1'b1;
                end else if ((state_q == RPT_REPEAT) && (cnt_q == CNT_W'(REPEAT_CYC - 1))) begin
                    cnt_d      = '0;
                    step_any_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RPT_IDLE;
                cnt_d   = '0;
            end
        endcase
        step_neg_c = step_any_c & ~dir_pos_d;
        step_pos_c = step_any_c & dir_pos_d;
    end

    // Axis state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q     <= 1'b0;
            pos_q     <= 1'b0;
            state_q   <= RPT_IDLE;
            dir_pos_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            neg_q     <= neg_d;
            pos_q     <= pos_d;
            state_q   <= state_d;
            dir_pos_q <= dir_pos_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/jstk_input_conditioner.sv
// PmodJSTK packet to cursor position, move pulse and debounced place/fire pulses.
module jstk_input_conditioner
    import jstk_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 2_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 40_000_000,
    parameter int unsigned REPEAT_CYC       = 15_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    jstk_input_conditioner_if.slave bus
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    jstk_pkt_t          pkt_c;
    logic               unused_pkt_bits;
    jstk_fields_t       fields_q, fields_d;
    logic               x_neg_c, x_pos_c, y_neg_c, y_pos_c;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic               move_q, move_d;

    logic               c_stable_q, c_stable_d, c_dly_q, c_dly_d, place_q, place_d;
    logic [DB_W-1:0]    c_cnt_q, c_cnt_d;
    logic               z_stable_q, z_stable_d, z_dly_q, z_dly_d, fire_q, fire_d;
    logic [DB_W-1:0]    z_cnt_q, z_cnt_d;

    assign pkt_c           = jstk_pkt_t'(bus.jstk_data);
    assign unused_pkt_bits = ^{pkt_c.rsvd_y, pkt_c.rsvd_x, pkt_c.rsvd_b, pkt_c.rsvd_b1};

    // Capture axis and button fields on the strobe; hold them otherwise.
    always_comb begin
        fields_d = fields_q;
        if (bus.jstk_valid) begin
            fields_d.x     = {pkt_c.x_hi, pkt_c.x_lo};
            fields_d.y     = {pkt_c.y_hi, pkt_c.y_lo};
            fields_d.btn_c = pkt_c.btn_c;
            fields_d.btn_z = pkt_c.btn_z;
        end
    end

    jstk_input_conditioner_axis #(
        .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
        .REPEAT_CYC       (REPEAT_CYC)
    ) u_axis_x (
        .clk        (clk),
        .reset      (reset),
        .axis_val   (fields_q.x),
        .step_neg_c (x_neg_c),
        .step_pos_c (x_pos_c)
    );

    jstk_input_conditioner_axis #(
        .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
        .REPEAT_CYC       (REPEAT_CYC)
    ) u_axis_y (
        .clk        (clk),
        .reset      (reset),
        .axis_val   (fields_q.y),
        .step_neg_c (y_neg_c),
        .step_pos_c (y_pos_c)
    );

    // Clamped cursor update; pulse only when a coordinate really moved.
    always_comb begin
        row_d  = step_coord(row_q, y_neg_c, y_pos_c);
        col_d  = step_coord(col_q, x_neg_c, x_pos_c);
        move_d = (row_d != row_q) || (col_d != col_q);
    end

    // C debouncer: flip after DEBOUNCE_CYC consecutive differing samples, pulse on stable rise.
    always_comb begin
        c_stable_d = c_stable_q;
        c_cnt_d    = '0;
        c_dly_d    = c_stable_q;
        place_d    = c_stable_q & ~c_dly_q;
        if (fields_q.btn_c != c_stable_q) begin
            if (c_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                c_stable_d = fields_q.btn_c;
            end else begin
                c_cnt_d = c_cnt_q + DB_W'(1);
            end
        end
    end

    // Z debouncer: same pattern as C.
    always_comb begin
        z_stable_d = z_stable_q;
        z_cnt_d    = '0;
        z_dly_d    = z_stable_q;
        fire_d     = z_stable_q & ~z_dly_q;
        if (fields_q.btn_z != z_stable_q) begin
            if (z_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                z_stable_d = fields_q.btn_z;
            end else begin
                z_cnt_d = z_cnt_q + DB_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fields_q.x     <= AXIS_W'(AXIS_MID);
            fields_q.y     <= AXIS_W'(AXIS_MID);
            fields_q.btn_c <= 1'b0;
            fields_q.btn_z <= 1'b0;
            row_q          <= COORD_W'(GRID_N / 2);
            col_q          <= COORD_W'(GRID_N / 2);
            move_q         <= 1'b0;
            c_stable_q     <= 1'b0;
            c_cnt_q        <= '0;
            c_dly_q        <= 1'b0;
            place_q        <= 1'b0;
            z_stable_q     <= 1'b0;
            z_cnt_q        <= '0;
            z_dly_q        <= 1'b0;
            fire_q         <= 1'b0;
        end else begin
            fields_q   <= fields_d;
            row_q      <= row_d;
            col_q      <= col_d;
            move_q     <= move_d;
            c_stable_q <= c_stable_d;
            c_cnt_q    <= c_cnt_d;
            c_dly_q    <= c_dly_d;
            place_q    <= place_d;
            z_stable_q <= z_stable_d;
            z_cnt_q    <= z_cnt_d;
            z_dly_q    <= z_dly_d;
            fire_q     <= fire_d;
        end
    end

    assign bus.sel_row     = row_q;
    assign bus.sel_col     = col_q;
    assign bus.move_pulse  = move_q;
    assign bus.place_pulse = place_q;
    assign bus.fire_pulse  = fire_q;

endmodule
